// File: rtl/clmul_iter_unit.sv
// Iterative carry-less multiplier (CLMUL/CLMULH/CLMULR) retiring BITS_PER_CYCLE
// multiplier bits per cycle, with early exit once the remaining multiplier is zero.
module clmul_iter_unit #(
  parameter int XLEN           = 64,
  parameter int BITS_PER_CYCLE = 4,
  parameter int TRANS_ID_BITS  = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic [1:0]               op_i,
  input  logic [XLEN-1:0]          operand_a_i,
  input  logic [XLEN-1:0]          operand_b_i,
  input  logic [TRANS_ID_BITS-1:0] trans_id_i,
  output logic                     result_valid_o,
  input  logic                     result_ready_i,
  output logic [XLEN-1:0]          result_o,
  output logic [TRANS_ID_BITS-1:0] result_trans_id_o
);

  localparam int NSTEP = XLEN / BITS_PER_CYCLE;
  localparam int CW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e                   state_q;
  logic [2*XLEN-1:0]        a_sh_q;
  logic [XLEN-1:0]          b_rem_q;
  logic [2*XLEN-1:0]        acc_q;
  logic [1:0]               op_q;
  logic [TRANS_ID_BITS-1:0] tag_q;
  logic [CW-1:0]            cnt_q;
  logic [XLEN-1:0]          result_q;
  logic                     result_valid_q;
  logic [TRANS_ID_BITS-1:0] result_tid_q;

  logic [2*XLEN-1:0]        acc_d;
  logic [2*XLEN-1:0]        a_sh_d;
  logic [XLEN-1:0]          b_rem_d;
  logic [XLEN-1:0]          result_d;
  logic [2*XLEN-1:0]        term [BITS_PER_CYCLE];

  // One partial product per multiplier bit retired this cycle.
  for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_term
    assign term[gi] = b_rem_q[gi] ? (a_sh_q << gi) : '0;
  end

  always_comb begin
    acc_d = acc_q;
    for (int j = 0; j < BITS_PER_CYCLE; j++) begin
      acc_d = acc_d ^ term[j];
    end
  end

  assign a_sh_d  = a_sh_q << BITS_PER_CYCLE;
  assign b_rem_d = b_rem_q >> BITS_PER_CYCLE;

  always_comb begin
    result_d = '0;
    case (op_q)
      2'b00:   result_d = acc_q[XLEN-1:0];
      2'b01:   result_d = acc_q[2*XLEN-1:XLEN];
      2'b10:   result_d = acc_q[2*XLEN-2:XLEN-1];
      default: result_d = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= IDLE;
      a_sh_q         <= '0;
      b_rem_q        <= '0;
      acc_q          <= '0;
      op_q           <= '0;
      tag_q          <= '0;
      cnt_q          <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      result_tid_q   <= '0;
    end else if (flush_i) begin
      state_q        <= IDLE;
      result_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (valid_i) begin
            a_sh_q  <= {{XLEN{1'b0}}, operand_a_i};
            b_rem_q <= operand_b_i;
            op_q    <= op_i;
            tag_q   <= trans_id_i;
            acc_q   <= '0;
            cnt_q   <= '0;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          acc_q   <= acc_d;
          a_sh_q  <= a_sh_d;
          b_rem_q <= b_rem_d;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == CW'(NSTEP - 1) || b_rem_d == '0) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          // First DONE cycle formats the accumulator into the output register.
          if (!result_valid_q) begin
            result_q       <= result_d;
            result_tid_q   <= tag_q;
            result_valid_q <= 1'b1;
          end else if (result_ready_i) begin
            result_valid_q <= 1'b0;
            state_q        <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready_o           = (state_q == IDLE);
  assign result_valid_o    = result_valid_q;
  assign result_o          = result_q;
  assign result_trans_id_o = result_tid_q;

endmodule
